// File: rtl/fifo_sync_flags.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sync_flags
// Description : Single-clock FIFO with arbitrary (non power-of-2) depth,
//               occupancy-derived status flags, rejected-access pulses and
//               optional overflow/underflow event counters.
//               FWFT_MODE = "TRUE"  : first-word fall-through read port
//               FWFT_MODE = "FALSE" : registered read port (1-cycle latency)
//               Optional feature macro: FIFO_SYNC_FLAGS_ERRCNT_EN
//                 defined   -> ovf_cnt/udf_cnt count rejected accesses,
//                              saturating at 16'hFFFF
//                 undefined -> ovf_cnt/udf_cnt tied to 0
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_sync_flags #(
    parameter string FWFT_MODE  = "FALSE",
    parameter int    DEPTH      = 8,
    parameter int    DATA_W     = 32,
    parameter int    AFULL_LVL  = DEPTH - 2,
    parameter int    AEMPTY_LVL = 2,
    parameter int    CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    // write port
    input  logic              w_req,
    input  logic [DATA_W-1:0] w_data,
    // read port
    input  logic              r_req,
    output logic [DATA_W-1:0] r_data,
    output logic              r_valid,
    // status
    output logic [CNT_W-1:0]  cnt,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic              w_fail,
    output logic              r_fail,
    output logic [15:0]       ovf_cnt,
    output logic [15:0]       udf_cnt
);

    // ------------------------------------------------------------------------
    // Local constants
    // ------------------------------------------------------------------------
    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // ------------------------------------------------------------------------
    // State and next-state
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  w_ptr_q, w_ptr_d;
    logic [PTR_W-1:0]  r_ptr_q, r_ptr_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    logic              empty_w;
    logic              full_w;
    logic              wr_acc;
    logic              rd_acc;
    logic              w_fail_w;
    logic              r_fail_w;
    logic [31:0]       cnt_ext;

    // ------------------------------------------------------------------------
    // Flags and access arbitration
    // ------------------------------------------------------------------------
    assign empty_w  = (cnt_q == '0);
    assign full_w   = (cnt_q == CNT_MAX);
    assign cnt_ext  = 32'(cnt_q);

    // A read is accepted whenever data is present. A write is accepted when
    // there is room, or when full but a read in the same cycle frees a slot.
    // Nothing is accepted (and nothing fails) while reset is held.
    assign rd_acc   = r_req & ~rst & ~empty_w;
    assign wr_acc   = w_req & ~rst & (~full_w | rd_acc);
    assign w_fail_w = w_req & ~rst & full_w & ~rd_acc;
    assign r_fail_w = r_req & ~rst & empty_w;

    assign cnt          = cnt_q;
    assign empty        = empty_w;
    assign full         = full_w;
    assign almost_full  = (cnt_ext >= 32'(AFULL_LVL));
    assign almost_empty = (cnt_ext <= 32'(AEMPTY_LVL));
    assign w_fail       = w_fail_w;
    assign r_fail       = r_fail_w;

    // Next-state for pointers (wrap at DEPTH-1, no masking) and occupancy
    always_comb begin
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        cnt_d   = cnt_q;

        if (wr_acc) begin
            w_ptr_d = (w_ptr_q == PTR_LAST) ? '0 : (w_ptr_q + PTR_ONE);
        end
        if (rd_acc) begin
            r_ptr_d = (r_ptr_q == PTR_LAST) ? '0 : (r_ptr_q + PTR_ONE);
        end

        case ({wr_acc, rd_acc})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and occupancy registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            cnt_q   <= '0;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage array; contents survive reset since empty gating hides them
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[w_ptr_q] <= w_data;
        end
    end

    // ------------------------------------------------------------------------
    // Read data path
    // ------------------------------------------------------------------------
    generate
        if (FWFT_MODE == "TRUE") begin : g_fwft
            // Head word is presented as soon as it is stored; 0 when empty
            assign r_data  = empty_w ? '0 : mem_q[r_ptr_q];
            assign r_valid = ~empty_w;
        end else begin : g_reg_read
            logic [DATA_W-1:0] rdata_q, rdata_d;
            logic              rvalid_q, rvalid_d;

            // Load the head word on an accepted read, otherwise hold
            always_comb begin
                rdata_d  = rdata_q;
                rvalid_d = rd_acc;
                if (rd_acc) begin
                    rdata_d = mem_q[r_ptr_q];
                end
            end

            // Output register and one-cycle valid pulse
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rdata_q  <= rdata_d;
                    rvalid_q <= rvalid_d;
                end
            end

            assign r_data  = rdata_q;
            assign r_valid = rvalid_q;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Rejected-access event counters
    // ------------------------------------------------------------------------
`ifdef FIFO_SYNC_FLAGS_ERRCNT_EN
    logic [15:0] ovf_q, ovf_d;
    logic [15:0] udf_q, udf_d;

    // Count each rejected cycle, sticking at all-ones
    always_comb begin
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (w_fail_w && (ovf_q != 16'hFFFF)) begin
            ovf_d = ovf_q + 16'd1;
        end
        if (r_fail_w && (udf_q != 16'hFFFF)) begin
            udf_d = udf_q + 16'd1;
        end
    end

    // Counter registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= '0;
            udf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign ovf_cnt = ovf_q;
    assign udf_cnt = udf_q;
`else
    assign ovf_cnt = '0;
    assign udf_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_flags.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_sync_flags
// Description : Self-checking bench for fifo_sync_flags. Two instances run
//               side by side: A = FWFT, DEPTH 5; B = registered read, DEPTH 8
//               with AFULL_LVL 6 / AEMPTY_LVL 2. Directed scenarios followed
//               by random traffic, compared against queue-based models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_sync_flags;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic        a_wr, a_rd;
    logic [31:0] a_wd, a_rdata;
    logic        a_rvalid, a_empty, a_full, a_aempty, a_afull, a_wfail, a_rfail;
    logic [2:0]  a_cnt;
    logic [15:0] a_ovf, a_udf;

    logic        b_wr, b_rd;
    logic [31:0] b_wd, b_rdata;
    logic        b_rvalid, b_empty, b_full, b_aempty, b_afull, b_wfail, b_rfail;
    logic [3:0]  b_cnt;
    logic [15:0] b_ovf, b_udf;

    fifo_sync_flags #(.FWFT_MODE("TRUE"), .DEPTH(5), .DATA_W(32)) u_a (
        .clk(clk), .rst(rst), .w_req(a_wr), .w_data(a_wd), .r_req(a_rd),
        .r_data(a_rdata), .r_valid(a_rvalid), .cnt(a_cnt), .empty(a_empty),
        .full(a_full), .almost_empty(a_aempty), .almost_full(a_afull),
        .w_fail(a_wfail), .r_fail(a_rfail), .ovf_cnt(a_ovf), .udf_cnt(a_udf)
    );

    fifo_sync_flags #(.FWFT_MODE("FALSE"), .DEPTH(8), .DATA_W(32),
                      .AFULL_LVL(6), .AEMPTY_LVL(2)) u_b (
        .clk(clk), .rst(rst), .w_req(b_wr), .w_data(b_wd), .r_req(b_rd),
        .r_data(b_rdata), .r_valid(b_rvalid), .cnt(b_cnt), .empty(b_empty),
        .full(b_full), .almost_empty(b_aempty), .almost_full(b_afull),
        .w_fail(b_wfail), .r_fail(b_rfail), .ovf_cnt(b_ovf), .udf_cnt(b_udf)
    );

    // Reference model state
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    int          a_ovf_m, a_udf_m, b_ovf_m, b_udf_m;
    logic [31:0] b_rdata_m;
    logic        b_rvalid_m;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int bump(input int v, input bit ev);
`ifdef FIFO_SYNC_FLAGS_ERRCNT_EN
        return (ev && v < 65535) ? v + 1 : v;
`else
        return 0;
`endif
    endfunction

    // Compare A's outputs for the current cycle against the model
    task automatic check_a(input bit wr, input bit rd);
        int n = qa.size();
        chk("a_cnt",    a_cnt,    n);
        chk("a_empty",  a_empty,  n == 0);
        chk("a_full",   a_full,   n == 5);
        chk("a_aempty", a_aempty, n <= 2);
        chk("a_afull",  a_afull,  n >= 3);
        chk("a_wfail",  a_wfail,  wr && n == 5 && !rd);
        chk("a_rfail",  a_rfail,  rd && n == 0);
        chk("a_rvalid", a_rvalid, n != 0);
        chk("a_rdata",  a_rdata,  (n != 0) ? qa[0] : 32'd0);
        chk("a_ovf",    a_ovf,    a_ovf_m);
        chk("a_udf",    a_udf,    a_udf_m);
    endtask

    task automatic check_b(input bit wr, input bit rd);
        int n = qb.size();
        chk("b_cnt",    b_cnt,    n);
        chk("b_empty",  b_empty,  n == 0);
        chk("b_full",   b_full,   n == 8);
        chk("b_aempty", b_aempty, n <= 2);
        chk("b_afull",  b_afull,  n >= 6);
        chk("b_wfail",  b_wfail,  wr && n == 8 && !rd);
        chk("b_rfail",  b_rfail,  rd && n == 0);
        chk("b_rvalid", b_rvalid, b_rvalid_m);
        chk("b_rdata",  b_rdata,  b_rdata_m);
        chk("b_ovf",    b_ovf,    b_ovf_m);
        chk("b_udf",    b_udf,    b_udf_m);
    endtask

    // Advance the models by one clock given this cycle's requests
    task automatic update_models(input bit wa, input logic [31:0] da, input bit ra,
                                 input bit wb, input logic [31:0] db, input bit rb);
        bit a_full_m  = (qa.size() == 5);
        bit a_empty_m = (qa.size() == 0);
        bit b_full_m  = (qb.size() == 8);
        bit b_empty_m = (qb.size() == 0);
        bit a_wf = wa && a_full_m && !ra;
        bit b_wf = wb && b_full_m && !rb;

        if (ra && !a_empty_m) void'(qa.pop_front());
        if (wa && !a_wf) qa.push_back(da);
        a_ovf_m = bump(a_ovf_m, a_wf);
        a_udf_m = bump(a_udf_m, ra && a_empty_m);

        if (rb && !b_empty_m) begin
            b_rdata_m  = qb[0];
            b_rvalid_m = 1'b1;
            void'(qb.pop_front());
        end else begin
            b_rvalid_m = 1'b0;
        end
        if (wb && !b_wf) qb.push_back(db);
        b_ovf_m = bump(b_ovf_m, b_wf);
        b_udf_m = bump(b_udf_m, rb && b_empty_m);
    endtask

    // One clock: drive on the falling edge, check, then let the rising edge hit
    task automatic step(input bit wa, input logic [31:0] da, input bit ra,
                        input bit wb, input logic [31:0] db, input bit rb);
        @(negedge clk);
        a_wr = wa; a_wd = da; a_rd = ra;
        b_wr = wb; b_wd = db; b_rd = rb;
        #1;
        check_a(wa, ra);
        check_b(wb, rb);
        update_models(wa, da, ra, wb, db, rb);
    endtask

    task automatic clear_models();
        qa.delete();
        qb.delete();
        a_ovf_m = 0; a_udf_m = 0; b_ovf_m = 0; b_udf_m = 0;
        b_rdata_m = '0; b_rvalid_m = 1'b0;
    endtask

    // Reset pulse between edges with requests active; outputs must react at once
    task automatic rst_pulse();
        @(negedge clk);
        a_wr = 1'b1; a_rd = 1'b1; a_wd = 32'hDEAD;
        b_wr = 1'b1; b_rd = 1'b1; b_wd = 32'hBEEF;
        #1 rst = 1'b1;
        #1;
        clear_models();
        check_a(1'b0, 1'b0);
        check_b(1'b0, 1'b0);
        #1;
        a_wr = 1'b0; a_rd = 1'b0; b_wr = 1'b0; b_rd = 1'b0;
        #1 rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        a_wr = 1'b0; a_rd = 1'b0; a_wd = '0;
        b_wr = 1'b0; b_rd = 1'b0; b_wd = '0;
        clear_models();
        #2;
        check_a(1'b0, 1'b0);
        check_b(1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // A: fill 1..5, reject a 6th write, read+write while full, drain
        for (int i = 1; i <= 5; i++) step(1, i, 0, 0, 0, 0);
        step(1, 6, 0, 0, 0, 0);
        step(1, 9, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 0, 0);

        // B: simultaneous read+write on empty, then registered read of 7
        step(0, 0, 0, 1, 7, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // B: fill to 8 and drain to 0, flags checked every cycle
        for (int i = 0; i < 9; i++) step(0, 0, 0, 1, 100 + i, 0);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);

        // Reset with three words queued; the next write must be the next read
        for (int i = 0; i < 3; i++) step(1, 50 + i, 0, 1, 60 + i, 0);
        rst_pulse();
        step(1, 32'hA, 0, 1, 32'hA, 0);
        step(0, 0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Error counters: 3 reads on empty, 2 writes on full
        rst_pulse();
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 1);
        for (int i = 0; i < 8; i++) step(i < 7, i, 0, 1, i, 0);
        for (int i = 0; i < 2; i++) step(0, 0, 0, 1, 99, 0);
        step(0, 0, 0, 0, 0, 0);
`ifdef FIFO_SYNC_FLAGS_ERRCNT_EN
        chk("a_ovf_total", a_ovf, 2);
        chk("a_udf_total", a_udf, 3);
        chk("b_ovf_total", b_ovf, 2);
        chk("b_udf_total", b_udf, 3);
`else
        chk("a_ovf_total", a_ovf, 0);
        chk("a_udf_total", a_udf, 0);
        chk("b_ovf_total", b_ovf, 0);
        chk("b_udf_total", b_udf, 0);
`endif

        // Random traffic with alternating fill/drain bias and rare resets
        for (int i = 0; i < 3000; i++) begin
            int wp = ((i / 150) % 2) ? 75 : 30;
            if ($urandom_range(0, 499) == 0) begin
                rst_pulse();
            end else begin
                step($urandom_range(0, 99) < wp, $urandom, $urandom_range(0, 99) >= wp,
                     $urandom_range(0, 99) < wp, $urandom, $urandom_range(0, 99) >= wp);
            end
        end
        step(0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
